// File: rtl/cim_loader_pkg.sv
// Shared types and defaults for the CIM weight loader.
package cim_loader_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic PING = 1'b0;
    localparam logic PONG = 1'b1;

    localparam int DEF_WEIGHT_BITS = 12;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_NUM_WORDS   = 144;

endpackage

// File: rtl/cim_weight_loader.sv
// Ping-pong weight loader for the digital CIM array.
// A valid/ready weight stream fills one bank while the MAC side computes on
// the other. Banks swap only on an explicit bank_release from the MAC side.
// Optional build macro CIM_LOADER_ERR_EN adds sticky err_release/err_overflow.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_FILL | write bank has room, stream words are accepted (unless flush)
// ST_WAIT | both banks full, stream stalled until the write bank is freed
module cim_weight_loader
    import cim_loader_pkg::*;
#(
    parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NUM_WORDS   = DEF_NUM_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WEIGHT_BITS-1:0] s_data,
    input  logic                   flush,
    input  logic                   bank_release,
    output logic                   bank_ready,
    output logic                   we,
    output logic [ADDR_WIDTH-1:0]  wa,
    output logic [WEIGHT_BITS-1:0] d_in,
    output logic                   write_to_pong_row,
    output logic                   mac_on_pong_row,
    output logic [ADDR_WIDTH-1:0]  fill_cnt
`ifdef CIM_LOADER_ERR_EN
    ,
    output logic                   err_release,
    output logic                   err_overflow
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    state_t                  state, state_next;
    logic [1:0]              full, full_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
    logic                    wr_next, mac_next;
    logic                    accept, done, rel_ok;

    // Next-state, handshake and bank tracker decisions for this cycle.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        rel_ok     = bank_release & bank_ready;
        full_next  = full;
        cnt_next   = cnt;
        wr_next    = write_to_pong_row;
        mac_next   = mac_on_pong_row;

        case (state)
            ST_FILL: begin
                s_ready = !flush;
                accept  = s_valid & !flush;
                if (flush) begin
                    cnt_next = '0;
                end else if (accept) begin
                    if (cnt == LAST_ADDR) begin
                        done     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!full[write_to_pong_row]) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase

        // Completion and release always hit different banks, so both apply.
        if (done) begin
            full_next[write_to_pong_row] = 1'b1;
            wr_next = (write_to_pong_row == PING) ? PONG : PING;
        end
        if (rel_ok) begin
            full_next[mac_on_pong_row] = 1'b0;
            mac_next = !mac_on_pong_row;
        end

        // Stall only if the bank we just swapped onto is still held by MAC.
        if (done && full_next[wr_next]) begin
            state_next = ST_WAIT;
        end
    end

    // State register, bank tracker and registered array write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= ST_FILL;
            full              <= 2'b00;
            cnt               <= '0;
            write_to_pong_row <= PING;
            mac_on_pong_row   <= PING;
            bank_ready        <= 1'b0;
            fill_cnt          <= '0;
            we                <= 1'b0;
            wa                <= '0;
            d_in              <= '0;
        end else begin
            state             <= state_next;
            full              <= full_next;
            cnt               <= cnt_next;
            write_to_pong_row <= wr_next;
            mac_on_pong_row   <= mac_next;
            bank_ready        <= full_next[mac_next];
            fill_cnt          <= cnt_next;
            we                <= accept;
            if (accept) begin
                wa   <= cnt;
                d_in <= s_data;
            end
        end
    end

`ifdef CIM_LOADER_ERR_EN
    localparam logic [ADDR_WIDTH:0] OVF_LOAD = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] ovf_tmr;

    // Sticky error flags; overflow fires once the stalled stream outlasts the timer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_release  <= 1'b0;
            err_overflow <= 1'b0;
            ovf_tmr      <= OVF_LOAD;
        end else begin
            if (bank_release && !bank_ready) begin
                err_release <= 1'b1;
            end
            if (s_valid && (state == ST_WAIT)) begin
                if (ovf_tmr == '0) begin
                    err_overflow <= 1'b1;
                end else begin
                    ovf_tmr <= ovf_tmr - 1'b1;
                end
            end else begin
                ovf_tmr <= OVF_LOAD;
            end
        end
    end
`endif

endmodule
